// File: rtl/op_select_encoder.sv
// Collects one-hot/multi-hot operation-select requests into a pending register and
// re-encodes them, one per handshake, into 3-bit ALU operation codes.
module op_select_encoder #(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] select,
   output logic [2:0] operation,
   output logic       op_valid,
   input  logic       op_ready,
   output logic [6:0] pending,
   output logic       busy,
   output logic       err
);

   logic [2:0] last_grant;
   logic [2:0] grant_idx;
   logic       found;
   logic       load;
   logic [6:0] grant_mask;

   // Index arithmetic is modulo 7, so code 7 can never be produced.
   function automatic logic [2:0] wrap7(input logic [3:0] s);
      return (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
   endfunction

   always_comb begin
      grant_idx = 3'd0;
      found     = 1'b0;
      if (ROUND_ROBIN) begin
         for (int k = 1; k <= 7; k++) begin
            if (!found && pending[wrap7({1'b0, last_grant} + 4'(k))]) begin
               found     = 1'b1;
               grant_idx = wrap7({1'b0, last_grant} + 4'(k));
            end
         end
      end else begin
         for (int i = 6; i >= 0; i--) begin
            if (pending[i]) begin
               found     = 1'b1;
               grant_idx = 3'(i);
            end
         end
      end
   end

   assign load       = !op_valid || op_ready;
   assign grant_mask = (load && found) ? (7'b1 << grant_idx) : 7'b0;
   assign busy       = (|pending) | op_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         pending    <= 7'd0;
         operation  <= 3'd0;
         op_valid   <= 1'b0;
         err        <= 1'b0;
         last_grant <= 3'd6;
      end else begin
         // A fresh request on the granted index wins over its clear.
         pending <= (pending & ~grant_mask) | select[6:0];
         if (select[7])
            err <= 1'b1;
         if (load) begin
            op_valid <= found;
            if (found) begin
               operation  <= grant_idx;
               last_grant <= grant_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_op_select_encoder.sv
// Scoreboard bench: round-robin and fixed-priority instances share stimulus;
// each scenario task checks the instance it targets.
module tb_op_select_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] select;
   logic       op_ready;

   logic [2:0] rr_operation, fp_operation;
   logic       rr_op_valid, fp_op_valid;
   logic [6:0] rr_pending, fp_pending;
   logic       rr_busy, fp_busy;
   logic       rr_err, fp_err;

   int checks = 0;
   int passed = 0;
   int exp_q[$];

   op_select_encoder #(.ROUND_ROBIN(1'b1)) dut_rr (
      .clk(clk), .reset(reset), .select(select), .operation(rr_operation),
      .op_valid(rr_op_valid), .op_ready(op_ready), .pending(rr_pending),
      .busy(rr_busy), .err(rr_err));

   op_select_encoder #(.ROUND_ROBIN(1'b0)) dut_fp (
      .clk(clk), .reset(reset), .select(select), .operation(fp_operation),
      .op_valid(fp_op_valid), .op_ready(op_ready), .pending(fp_pending),
      .busy(fp_busy), .err(fp_err));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; select = 8'h00; op_ready = 1'b1;
      exp_q.delete();
      step(); step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1; select = 8'h00; op_ready = 1'b1;
      step(); step();
      checks++;
      if ({rr_pending, rr_operation, rr_op_valid, rr_busy, rr_err} !== 13'd0)
         $display("FAIL reset_rr: got pend=%h op=%0d v=%b busy=%b err=%b, want all 0",
                  rr_pending, rr_operation, rr_op_valid, rr_busy, rr_err);
      else passed++;
      checks++;
      if ({fp_pending, fp_operation, fp_op_valid, fp_busy, fp_err} !== 13'd0)
         $display("FAIL reset_fp: got pend=%h op=%0d v=%b busy=%b err=%b, want all 0",
                  fp_pending, fp_operation, fp_op_valid, fp_busy, fp_err);
      else passed++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_single();
      int e;
      do_reset();
      select = 8'h04; exp_q.push_back(2);
      step();
      select = 8'h00;
      checks++;
      if (rr_pending !== 7'h04 || rr_op_valid !== 1'b0 || rr_busy !== 1'b1)
         $display("FAIL single_capture: pend=%h v=%b busy=%b, want pend=04 v=0 busy=1",
                  rr_pending, rr_op_valid, rr_busy);
      else passed++;
      step();
      e = exp_q.pop_front();
      checks++;
      if (rr_op_valid !== 1'b1 || rr_operation !== 3'(e))
         $display("FAIL single_issue: v=%b op=%0d, want v=1 op=%0d", rr_op_valid, rr_operation, e);
      else passed++;
      step();
      checks++;
      if (rr_op_valid !== 1'b0 || rr_busy !== 1'b0)
         $display("FAIL single_idle: v=%b busy=%b, want 0 0", rr_op_valid, rr_busy);
      else passed++;
   endtask

   task automatic test_rr_fair();
      int e;
      do_reset();
      select = 8'h7F;
      for (int i = 0; i < 7; i++) exp_q.push_back(i);
      step();
      select = 8'h00;
      step();
      for (int i = 0; i < 7; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rr_op_valid !== 1'b1 || rr_operation !== 3'(e))
            $display("FAIL rr_seq[%0d]: v=%b op=%0d, want v=1 op=%0d", i, rr_op_valid, rr_operation, e);
         else passed++;
         step();
      end
      checks++;
      if (rr_op_valid !== 1'b0)
         $display("FAIL rr_seq_end: v=%b, want 0", rr_op_valid);
      else passed++;
      select = 8'h41; exp_q.push_back(0); exp_q.push_back(6);
      step();
      select = 8'h00;
      step();
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (rr_op_valid !== 1'b1 || rr_operation !== 3'(e))
            $display("FAIL rr_wrap[%0d]: v=%b op=%0d, want v=1 op=%0d", i, rr_op_valid, rr_operation, e);
         else passed++;
         step();
      end
      checks++;
      if (rr_op_valid !== 1'b0)
         $display("FAIL rr_wrap_end: v=%b, want 0", rr_op_valid);
      else passed++;
   endtask

   task automatic test_fixed_priority();
      int e;
      do_reset();
      select = 8'h4A;
      exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(6);
      step();
      select = 8'h00;
      checks++;
      if (fp_pending !== 7'h4A)
         $display("FAIL fp_capture: pend=%h, want 4a", fp_pending);
      else passed++;
      step();
      // late request for bit 0 arrives while index 1 is on the output
      select = 8'h01;
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (fp_op_valid !== 1'b1 || fp_operation !== 3'(e))
            $display("FAIL fp_seq[%0d]: v=%b op=%0d, want v=1 op=%0d", i, fp_op_valid, fp_operation, e);
         else passed++;
         step();
         select = 8'h00;
      end
      checks++;
      if (fp_op_valid !== 1'b0)
         $display("FAIL fp_seq_end: v=%b, want 0", fp_op_valid);
      else passed++;
   endtask

   task automatic test_backpressure();
      int e;
      do_reset();
      op_ready = 1'b0;
      select = 8'h03; exp_q.push_back(0); exp_q.push_back(1);
      step();
      select = 8'h00;
      step();
      e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rr_op_valid !== 1'b1 || rr_operation !== 3'(e) || rr_pending !== 7'h02)
            $display("FAIL bp_hold[%0d]: v=%b op=%0d pend=%h, want v=1 op=%0d pend=02",
                     i, rr_op_valid, rr_operation, rr_pending, e);
         else passed++;
         step();
      end
      op_ready = 1'b1;
      step();
      e = exp_q.pop_front();
      checks++;
      if (rr_op_valid !== 1'b1 || rr_operation !== 3'(e))
         $display("FAIL bp_release: v=%b op=%0d, want v=1 op=%0d", rr_op_valid, rr_operation, e);
      else passed++;
      step();
      checks++;
      if (rr_op_valid !== 1'b0 || rr_busy !== 1'b0)
         $display("FAIL bp_end: v=%b busy=%b, want 0 0", rr_op_valid, rr_busy);
      else passed++;
   endtask

   task automatic test_set_wins();
      int n;
      do_reset();
      select = 8'h08;
      step(); step();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (rr_op_valid !== 1'b1 || rr_operation !== 3'd3 || rr_pending[3] !== 1'b1)
            $display("FAIL setwins[%0d]: v=%b op=%0d pend=%h, want v=1 op=3 pend[3]=1",
                     i, rr_op_valid, rr_operation, rr_pending);
         else passed++;
         step();
      end
      select = 8'h00;
      n = 0;
      while (rr_op_valid && n < 10) begin step(); n++; end
      checks++;
      if (rr_op_valid !== 1'b0 || rr_pending !== 7'h00)
         $display("FAIL setwins_drain: v=%b pend=%h after %0d cycles, want v=0 pend=00",
                  rr_op_valid, rr_pending, n);
      else passed++;
   endtask

   task automatic test_coalesce();
      int n;
      do_reset();
      op_ready = 1'b0;
      select = 8'h08;
      step();
      select = 8'h00;
      step();
      for (int i = 0; i < 3; i++) begin
         select = 8'h08; step();
         select = 8'h00; step();
      end
      checks++;
      if (rr_op_valid !== 1'b1 || rr_operation !== 3'd3 || rr_pending !== 7'h08)
         $display("FAIL coal_stall: v=%b op=%0d pend=%h, want v=1 op=3 pend=08",
                  rr_op_valid, rr_operation, rr_pending);
      else passed++;
      op_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 10 && rr_op_valid; c++) begin
         if (rr_operation == 3'd3) n++;
         step();
      end
      checks++;
      if (n !== 2 || rr_op_valid !== 1'b0)
         $display("FAIL coal_count: issues of 3=%0d v=%b, want 2 issues then v=0", n, rr_op_valid);
      else passed++;
   endtask

   task automatic test_reserved_reset();
      do_reset();
      select = 8'h80;
      step();
      select = 8'h00;
      checks++;
      if (rr_err !== 1'b1 || rr_pending !== 7'h00 || fp_err !== 1'b1)
         $display("FAIL reserved: err=%b/%b pend=%h, want err=1/1 pend=00", rr_err, fp_err, rr_pending);
      else passed++;
      step();
      checks++;
      if (rr_op_valid !== 1'b0 || rr_err !== 1'b1)
         $display("FAIL reserved_noissue: v=%b err=%b, want v=0 err=1", rr_op_valid, rr_err);
      else passed++;
      op_ready = 1'b0;
      select = 8'h7F;
      step(); step();
      select = 8'h00;
      checks++;
      if (rr_pending !== 7'h7F || rr_op_valid !== 1'b1)
         $display("FAIL prereset: pend=%h v=%b, want pend=7f v=1", rr_pending, rr_op_valid);
      else passed++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({rr_pending, rr_operation, rr_op_valid, rr_busy, rr_err} !== 13'd0)
         $display("FAIL midreset: pend=%h op=%0d v=%b busy=%b err=%b, want all 0",
                  rr_pending, rr_operation, rr_op_valid, rr_busy, rr_err);
      else passed++;
   endtask

   initial begin
      reset = 1'b1; select = 8'h00; op_ready = 1'b1;
      test_reset();
      test_single();
      test_rr_fair();
      test_fixed_priority();
      test_backpressure();
      test_set_wins();
      test_coalesce();
      test_reserved_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/op_select_encoder.md
Name: op_select_encoder

Overview:
- Reverse direction of the ALU operation decoder: collects one-hot operation-select requests and re-encodes them into 3-bit operation codes for the ALU control path.
- Requests arrive as an 8-bit select bus; bits 0..6 map to operation codes 0..6 and bit 7 is reserved.
- Requests are held in a pending register and issued one at a time over a valid/ready handshake.
- Arbitration between pending requests is round-robin or fixed-priority.

Parameters:
- ROUND_ROBIN, 1: 1 selects round-robin arbitration; 0 selects fixed priority, where the lowest index wins.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- select  input  8  one-hot/multi-hot request bus. Bit i requests operation i for i = 0..6. Bit 7 is reserved.
- operation  output  3  encoded operation code. Registered; valid only while op_valid = 1.
- op_valid  output  1  operation holds a code to be consumed.
- op_ready  input  1  consumer accepts operation this cycle.
- pending  output  7  current pending-request register (bits 0..6).
- busy  output  1  equals (|pending) | op_valid.
- err  output  1  sticky flag, set when select[7] is seen high.
- Interface decision: one clock; reset is synchronous and active-high. Ports are named clk and reset.

Behaviour:
- Reset (synchronous, overrides everything): pending = 0, operation = 3'd0, op_valid = 0, err = 0, last_grant = 3'd6, so the first round-robin search starts at 0. Asserting reset mid-operation discards all pending and in-flight codes. The cycle after reset deasserts is idle.
- Capture:
  - pending_next = (pending & ~grant_mask) | select[6:0].
  - A request bit set in the same cycle its index is granted stays pending; the new request wins over the clear.
  - Repeated requests for an already-pending index coalesce into one; requests are not counted.
  - select[7] is never captured. It sets err = 1, which stays set until reset.
- Issue stage (load condition: !op_valid || op_ready):
  - If pending != 0: choose an index g, set operation = g and op_valid = 1, and clear bit g through grant_mask.
  - If pending == 0: op_valid = 0 and operation holds its previous value.
- Hold: while op_valid && !op_ready, operation and op_valid are held stable and grant_mask = 0.
- Arbitration:
  - ROUND_ROBIN = 1: search indices last_grant+1, last_grant+2, ... modulo 7 (range 0..6, so 6 wraps to 0). The first pending index wins. last_grant is updated to g on every grant.
  - ROUND_ROBIN = 0: the lowest set index wins; last_grant is unused.
- Latency:
  - A select bit high in cycle N becomes pending at the end of N.
  - op_valid rises in cycle N+2 at the earliest. There is no bypass path.
- Throughput: one code per cycle when op_ready is held high and pending is non-empty (back-to-back issue).
- Code 3'd7 is never emitted.
- Arbitration sees only the registered pending value. A same-cycle select does not participate until the next cycle.
- busy is combinational from registers only.

Test Plan:
- Single request: reset, then pulse select = 8'h04 for one cycle with op_ready = 1. Required: pending = 7'h04 in the next cycle; op_valid = 1 with operation = 3'd2 two cycles after the pulse; op_valid = 0 after that; busy then deasserts.
- Round-robin fairness (ROUND_ROBIN = 1): pulse select = 8'h7F once with op_ready = 1. Required: operations 0,1,2,3,4,5,6 issued on consecutive cycles, then op_valid = 0. Then pulse 8'h41 with last_grant = 6. Required order: 0, then 6.
- Fixed priority (ROUND_ROBIN = 0): pending = 7'h4A. Required order: 1, 3, 6. A new request for bit 0 arriving mid-sequence is issued before the remaining higher indices.
- Backpressure: op_ready = 0 with pending = 7'h03. Required: operation = 0 held with op_valid = 1 for 5 cycles and pending stays 7'h02. Raise op_ready. Required: operation = 1 on the next cycle.
- Set-wins collision and coalescing:
  - Hold select = 8'h08 continuously with op_ready = 1. Required: operation = 3 reissued every cycle and pending[3] never clears.
  - Pulse 8'h08 three times while index 3 is stalled. Required: exactly one extra issue of 3.
- Reserved bit and reset: select = 8'h80. Required: err = 1, pending = 0, no issue. Assert reset while pending = 7'h7F and op_valid = 1. Required: all outputs zero in the next cycle and err cleared.
